// File: rtl/de_hazard_ctrl.sv
// de_hazard_ctrl
// Hazard and flush control for the F/D and D/E pipeline registers of the
// barrel RISC-V core.
//   - Same-thread load-use hazards hold F and D for one cycle and insert a
//     bubble into E.
//   - Execute-stage redirects (taken branch or jump) flush the younger
//     same-thread instructions in D and F.
//   - A per-thread kill mask remembers the one stale fetch that is still in
//     flight after a redirect, and squashes it when it arrives in F.
//   - Two saturating counters record stall cycles and flush cycles.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_valid_i, tid_f_i     fetch word present in F and its thread
//   tid_d_i, rs1_d_i, rs2_d_i  thread and source registers of the D instruction
//   tid_e_i, rd_e_i            thread and destination register of the E instruction
//   reg_write_e_i, res_src_e_i E writes rd; result source (2'b01 = load)
//   pc_src_e_i                 E redirects the PC
//   stall_f_o, stall_d_o       hold F/D (and PC file), hold D/E
//   flush_d_o, flush_e_o       clear F/D, load a bubble into D/E
//   kill_mask_o                registered per-thread stale-fetch flags
//   stall_cnt_o, flush_cnt_o   saturating event counters
module de_hazard_ctrl #(
  parameter int BITS_THREADS = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_valid_i,
  input  logic [BITS_THREADS-1:0]     tid_f_i,
  input  logic [BITS_THREADS-1:0]     tid_d_i,
  input  logic [4:0]                  rs1_d_i,
  input  logic [4:0]                  rs2_d_i,
  input  logic [BITS_THREADS-1:0]     tid_e_i,
  input  logic [4:0]                  rd_e_i,
  input  logic                        reg_write_e_i,
  input  logic [1:0]                  res_src_e_i,
  input  logic                        pc_src_e_i,
  output logic                        stall_f_o,
  output logic                        stall_d_o,
  output logic                        flush_d_o,
  output logic                        flush_e_o,
  output logic [(2**BITS_THREADS)-1:0] kill_mask_o,
  output logic [CNT_WIDTH-1:0]        stall_cnt_o,
  output logic [CNT_WIDTH-1:0]        flush_cnt_o
);

  localparam int THREADS = 2**BITS_THREADS;

  logic [THREADS-1:0]   kill_mask;
  logic [THREADS-1:0]   kill_next;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic                 lu;
  logic                 rd_x;
  logic                 sf;
  logic                 stall_core;
  logic                 flush_d_core;
  logic                 flush_e_core;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 en);
    if (en && (cnt != {CNT_WIDTH{1'b1}}))
      return cnt + CNT_WIDTH'(1);
    return cnt;
  endfunction

  // Hazard detection: purely combinational from the inputs and the kill mask
  always_comb begin
    lu = (res_src_e_i == 2'b01) && reg_write_e_i && (rd_e_i != 5'd0) &&
         (tid_e_i == tid_d_i) && ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
    rd_x = pc_src_e_i;
    sf   = fetch_valid_i && kill_mask[tid_f_i];

    // A redirect discards the D instruction anyway, so it overrides the stall.
    stall_core   = lu && !rd_x;
    flush_e_core = lu || (rd_x && (tid_d_i == tid_e_i));
    flush_d_core = sf || (rd_x && fetch_valid_i && (tid_f_i == tid_e_i));
  end

  // While reset is held, force bubbles into both pipeline registers.
  assign stall_d_o   = rst_n & stall_core;
  assign stall_f_o   = rst_n & stall_core;
  assign flush_e_o   = ~rst_n | flush_e_core;
  assign flush_d_o   = ~rst_n | flush_d_core;
  assign kill_mask_o = kill_mask;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

  // Kill mask next state: set wins over clear; nothing clears while F is
  // stalled because the stale word is still sitting in the F/D register.
  always_comb begin
    kill_next = kill_mask;
    for (int t = 0; t < THREADS; t++) begin
      if (rd_x && (tid_e_i == BITS_THREADS'(t)))
        kill_next[t] = 1'b1;
      else if (sf && !stall_core && (tid_f_i == BITS_THREADS'(t)))
        kill_next[t] = 1'b0;
    end
  end

  // State registers: kill mask and event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_mask <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      kill_mask <= kill_next;
      stall_cnt <= sat_inc(stall_cnt, stall_core);
      flush_cnt <= sat_inc(flush_cnt, flush_e_core || flush_d_core);
    end
  end

endmodule

// File: doc/de_hazard_ctrl.md
# de_hazard_ctrl

Hazard and flush controller that drives the stall/clear inputs of the fetch/decode and decode/execute pipeline registers in the barrel RISC-V core. It is the control side of the D/E register interface: it decides when that register holds (en high), when it loads a bubble (clr high), and when it captures the next decoded instruction. It detects same-thread load-use hazards and execute-stage redirects (taken branch/jump), and keeps a per-thread kill mask for the one stale fetch in flight after a redirect. It also maintains saturating stall and flush event counters for performance debug.

## Interface
- BITS_THREADS, 3, thread-id width; THREADS = 2**BITS_THREADS.
- CNT_WIDTH, 16, width of each event counter.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_valid_i  in  1  instruction-memory data for tid_f_i is present in F this cycle.
- tid_f_i  in  BITS_THREADS  thread of the instruction in F (the F/D register input).
- tid_d_i  in  BITS_THREADS  thread of the instruction in D (the D/E register input).
- rs1_d_i, rs2_d_i  in  5 each  source registers of the instruction in D.
- tid_e_i  in  BITS_THREADS  thread of the instruction in E (the D/E register output).
- rd_e_i  in  5  destination register of the instruction in E.
- reg_write_e_i  in  1  the instruction in E writes rd.
- res_src_e_i  in  2  result source of E; 2'b01 = load.
- pc_src_e_i  in  1  the instruction in E redirects the PC (taken branch or jump).
- stall_f_o  out  1  hold the PC file and the F/D register.
- stall_d_o  out  1  to the D/E register en; 1 = hold.
- flush_d_o  out  1  synchronous clear of the F/D register.
- flush_e_o  out  1  to the D/E register clr; 1 = load a bubble.
- kill_mask_o  out  THREADS  registered per-thread stale-fetch flags.
- stall_cnt_o, flush_cnt_o  out  CNT_WIDTH each  saturating event counters.

## Operation
- Load-use hazard (lu): res_src_e_i==2'b01, reg_write_e_i, rd_e_i!=0, tid_e_i==tid_d_i, and rd_e_i equals rs1_d_i or rs2_d_i.
- Redirect (rd_x): pc_src_e_i==1.
- Stale fetch (sf): fetch_valid_i and kill_mask[tid_f_i]==1.
- flush_e_o = lu OR (rd_x AND tid_d_i==tid_e_i).
- stall_d_o = lu AND NOT rd_x. Redirect overrides stall. The D/E register applies clr above en.
- stall_f_o = stall_d_o.
- flush_d_o = sf OR (rd_x AND fetch_valid_i AND tid_f_i==tid_e_i).
- Kill mask update on each edge, per thread t:
  - Set when rd_x and tid_e_i==t. The fetch already addressed for t returns stale one cycle later.
  - Cleared when sf and tid_f_i==t, with stall_f_o low.
  - Set wins over clear in the same cycle.
  - While stall_f_o is high, no bit is cleared. The stale word is still held.
- stall_cnt_o increments on each cycle with stall_d_o==1. flush_cnt_o increments on each cycle with flush_e_o OR flush_d_o. Both saturate at 2**CNT_WIDTH-1 and never wrap.
- All outputs depend only on current inputs and the registered kill mask. There is no multi-cycle FSM beyond the per-thread kill bits.

## Timing
- stall/flush outputs are combinational from the inputs, with zero latency. They take effect at the same edge that would otherwise load the pipeline registers.
- Kill mask and counters update on the rising clk edge. They are visible on kill_mask_o and the counter outputs in the following cycle.
- Asynchronous reset (rst_n low):
  - kill_mask_o=0; stall_cnt_o=0; flush_cnt_o=0.
  - While rst_n is low: stall_f_o=0, stall_d_o=0, flush_d_o=1, flush_e_o=1, so the pipe loads bubbles.
- Reset released mid-operation: the first edge with rst_n high uses normal equations. No stale kill bits survive reset.
- A load-use hazard lasts exactly as long as the load stays in E. The bubble inserted by flush_e_o removes the hazard on the next cycle, so the stall is one cycle per hazard.
- Simultaneous lu and rd_x for the same thread: flush only, no stall. stall_cnt_o does not increment; flush_cnt_o does.

## Test plan
- Load-use: E=(load, tid 2, rd x5), D=(tid 2, rs1 x5). Required: stall_f=stall_d=flush_e=1 for one cycle, then 0. stall_cnt 0->1.
- Different thread: same as above but D tid 3. Required: all stall/flush outputs 0.
- rd_e=x0: load writing x0 with matching rs1=x0. Required: no stall, no flush.
- Redirect tid 4 with D tid 4 and F tid 1: flush_e=1, flush_d=0. Next cycle kill_mask_o=0x10. Fetch tid 4 arrives later: flush_d=1, then kill_mask_o=0x00.
- Redirect coinciding with load-use, same thread: flush_e=1, stall_d=0. Counters: flush+1, stall+0.
- Saturation and reset: CNT_WIDTH=4 with 20 stall cycles: stall_cnt_o holds 15. Assert rst_n low mid-run: counters and kill_mask drop to 0 immediately, and flush_d=flush_e=1 while reset is held.
